// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - size and state encodings shared by the memory responder, controller and datapath
package mem_responder_pkg;

    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = lane[0];
            SIZE_WORD: is_misaligned = (lane != 2'b00);
            default:   is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request/response port between the core and the data memory responder
interface mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_unsigned, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - little-endian lane select with sign/zero extension for loads
module mem_load_align
    import mem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        zero_ext,
    output logic [31:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = word[{lane, 3'b000} +: 8];
        sel_half = lane[1] ? word[31:16] : word[15:0];
        case (size)
            SIZE_BYTE: data = zero_ext ? {24'h0, sel_byte} : {{24{sel_byte[7]}}, sel_byte};
            SIZE_HALF: data = zero_ext ? {16'h0, sel_half} : {{16{sel_half[15]}}, sel_half};
            SIZE_WORD: data = word;
            default:   data = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - byte-lane data memory responder; MEM_WAIT_EN adds WAIT_CYCLES wait states per request
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);

    logic [1:0]            state;
    logic                  lat_we;
    logic                  lat_uns;
    logic [ADDR_WIDTH+1:0] lat_addr;
    logic [1:0]            lat_size;
    logic [31:0]           lat_wdata;
    logic [31:0]           word_q;
    logic                  err_q;
    logic                  resp_valid_q;
    logic                  resp_err_q;
    logic [31:0]           resp_rdata_q;
    logic [31:0]           load_data;
    logic [3:0]            byte_en;
    logic [31:0]           lane_wdata;
    logic                  bad;
    logic [ADDR_WIDTH-1:0] word_idx;
    logic [1:0]            lane;
    logic [31:0]           mem [2**ADDR_WIDTH];

`ifdef MEM_WAIT_EN
    logic [3:0]            wait_cnt;
    logic                  unused_addr;
    assign unused_addr = ^bus.req_addr[31:ADDR_WIDTH+2];
`else
    logic                  unused_addr;
    assign unused_addr = ^{bus.req_addr[31:ADDR_WIDTH+2], (WAIT_CYCLES != 0)};
`endif

    assign word_idx = lat_addr[ADDR_WIDTH+1:2];
    assign lane     = lat_addr[1:0];
    assign bad      = is_misaligned(lat_size, lane);

    // Stores replicate the narrow data across the word; byte_en picks the lane(s) that land.
    always_comb begin
        byte_en    = 4'b0000;
        lane_wdata = lat_wdata;
        case (lat_size)
            SIZE_BYTE: begin
                byte_en    = 4'b0001 << lane;
                lane_wdata = {4{lat_wdata[7:0]}};
            end
            SIZE_HALF: begin
                byte_en    = lane[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{lat_wdata[15:0]}};
            end
            SIZE_WORD: byte_en = 4'b1111;
            default:   byte_en = 4'b0000;
        endcase
    end

    mem_load_align u_align (
        .word     (word_q),
        .lane     (lane),
        .size     (lat_size),
        .zero_ext (lat_uns),
        .data     (load_data)
    );

    always_ff @(posedge clk) begin
        if (state == ST_ACCESS) begin
            if (!rst && lat_we && !bad) begin
                for (int b = 0; b < 4; b++) begin
                    if (byte_en[b]) mem[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
                end
            end
            word_q <= mem[word_idx];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            lat_we       <= 1'b0;
            lat_uns      <= 1'b0;
            lat_addr     <= '0;
            lat_size     <= SIZE_BYTE;
            lat_wdata    <= 32'h0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
`ifdef MEM_WAIT_EN
            wait_cnt     <= 4'd0;
`endif
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        lat_we    <= bus.req_we;
                        lat_uns   <= bus.req_unsigned;
                        lat_addr  <= bus.req_addr[ADDR_WIDTH+1:0];
                        lat_size  <= bus.req_size;
                        lat_wdata <= bus.req_wdata;
`ifdef MEM_WAIT_EN
                        if (WAIT_CYCLES > 0) begin
                            wait_cnt <= 4'(WAIT_CYCLES);
                            state    <= ST_WAIT;
                        end else begin
                            state    <= ST_ACCESS;
                        end
`else
                        state     <= ST_ACCESS;
`endif
                    end
                end
`ifdef MEM_WAIT_EN
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) state <= ST_ACCESS;
                end
`endif
                ST_ACCESS: begin
                    err_q <= bad;
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= err_q;
                    resp_rdata_q <= (err_q || lat_we) ? 32'h0 : load_data;
                    state        <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready  = (state == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: doc/mem_responder.md
# mem_responder

Data-memory responder for the multicycle MIPS core. It sits on the far side of the controller/datapath memory port: it accepts one load or store request at a time and performs byte-lane writes for SB/SH/SW. It returns aligned, sign- or zero-extended read data for LB/LBU/LH/LHU/LW, and flags misaligned accesses. An optional wait-state counter models slow memory so the controller's stall path can be exercised.

## Interface
- ADDR_WIDTH, 10, word-address bits; array depth is 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2, wait states inserted before the access; only used when MEM_WAIT_EN is defined; legal range 0..15.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address; bits [ADDR_WIDTH+1:2] select the word, higher bits ignored (wrap).
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  zero-extend loads (LBU/LHU); ignored for word and stores.
- req_wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  output  1  one-cycle pulse: response data/status valid.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned or illegal-size request, valid with resp_valid.

## Operation
- States: IDLE, WAIT, ACCESS, RESP.
- IDLE: req_ready=1; on req_valid latch we/addr/size/unsigned/wdata, go to WAIT (if MEM_WAIT_EN and WAIT_CYCLES>0, counter loaded with WAIT_CYCLES) else ACCESS.
- WAIT: counter decrements each cycle; at 1 go to ACCESS.
- ACCESS: check alignment. Error when size=11, size=01 with addr[0]=1, or size=10 with addr[1:0]≠00. Otherwise store writes only the selected lanes at the closing edge; load registers the word. Go to RESP.
- RESP: resp_valid=1 for exactly one cycle; go to IDLE.
- Little-endian lanes: byte lane = addr[1:0]; half lane = addr[1] (bytes 0-1 or 2-3).
- Store lane data: byte → wdata[7:0] into lane; half → wdata[15:0] into lane; word → full word. Unselected bytes unchanged.
- Load extension: byte/half extracted from lane, then sign-extended unless req_unsigned, which zero-extends.
- Error: no array write, resp_rdata=0, resp_err=1.
- Inputs other than req_valid are ignored outside IDLE; the latched copy is used.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, wait counter 0. Array contents are not reset.
- Request accepted at edge t (req_valid sampled high in IDLE). resp_valid is high in the cycle after edge t+2+W, where W = WAIT_CYCLES with MEM_WAIT_EN and 0 without it.
- The store write commits at edge t+1+W; a load issued afterwards sees the new data.
- req_ready is low from edge t until RESP exits. The next acceptance is no earlier than edge t+3+W, so throughput is one request per 3+W cycles.
- resp_rdata and resp_err hold their values after resp_valid drops until the next RESP.
- Reset asserted mid-operation, including during WAIT or ACCESS, returns to IDLE immediately. No array write occurs unless the ACCESS closing edge completed before rst rose.

## Configuration
- MEM_WAIT_EN defined: WAIT state and 4-bit counter are built, and WAIT_CYCLES wait states are inserted per request.
- MEM_WAIT_EN undefined: no WAIT state or counter; IDLE goes directly to ACCESS; WAIT_CYCLES is ignored.

## Structure
- The shared package holds the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the state encodings. These are shared with the controller and datapath definitions.
- Sub-module mem_load_align: combinational lane select plus sign/zero extension (word, addr[1:0], size, unsigned → 32-bit data). It is reused by the bench model.

## Test plan
- Reset check: after rst deasserts → req_ready=1, resp_valid=0; no spurious response in the following 20 cycles.
- Store word 0xDEADBEEF at 0x10, then LW 0x10 → resp_rdata=0xDEADBEEF, resp_err=0; resp_valid lands exactly at edge t+2+W.
- Store byte 0x80 at 0x13 over word 0x00000000. LB 0x13 → 0xFFFFFF80; LBU 0x13 → 0x00000080; LW 0x10 → 0x80000000.
- Store half 0x8001 at 0x22. LH 0x22 → 0xFFFF8001; LHU → 0x00008001; bytes 0x20-0x21 unchanged.
- Misaligned accesses: LH 0x21 and SW 0x12 → resp_err=1, resp_rdata=0; the word at 0x10 is unchanged. size=11 → resp_err=1.
- With MEM_WAIT_EN and WAIT_CYCLES=3: assert rst during WAIT of SW 0x30 → IDLE, and a later LW 0x30 returns the old value. Also verify resp_valid latency is 5 cycles.
